// File: rtl/refresh_sched_if.sv
// Hold/command handshake between the refresh scheduler (master) and the
// transaction engine / DFI command mux (slave).
interface refresh_sched_if;
    logic       tran_idle;
    logic       hold_req;
    logic       hold_ack;
    logic       ref_cmd_valid;
    logic [1:0] ref_cmd_type;
    logic       ref_cmd_ready;

    modport master (
        input  tran_idle,
        input  hold_ack,
        input  ref_cmd_ready,
        output hold_req,
        output ref_cmd_valid,
        output ref_cmd_type
    );

    modport slave (
        output tran_idle,
        output hold_ack,
        output ref_cmd_ready,
        input  hold_req,
        input  ref_cmd_valid,
        input  ref_cmd_type
    );
endinterface

// File: rtl/refresh_sched.sv
// Periodic DRAM refresh scheduler: tREFI tracking, bounded refresh debt, PREA + REF issue.
// Define REFSCHED_OVERFLOW_EN to build the sticky ref_overflow detector (tied low otherwise).
module refresh_sched #(
    parameter int unsigned TREFI_CYC   = 1950,
    parameter int unsigned TRP_CYC     = 4,
    parameter int unsigned TRFC_CYC    = 65,
    parameter int unsigned MAX_DEBT    = 8,
    parameter int unsigned URGENT_DEBT = 6
) (
    input  logic                   core_clk,
    input  logic                   core_arstn,
    input  logic                   ref_en,
    refresh_sched_if.master        ref_bus,
    output logic [3:0]             ref_debt,
    output logic                   ref_urgent,
    output logic                   ref_done,
    output logic                   ref_overflow
);

    localparam int unsigned CNT_W    = $clog2(TREFI_CYC + 1);
    localparam int unsigned WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [3:0]  DEBT_MAX = 4'(MAX_DEBT);
    localparam logic [3:0]  DEBT_URG = 4'(URGENT_DEBT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_PREA = 3'd2,
        S_TRP  = 3'd3,
        S_REF  = 3'd4,
        S_TRFC = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    ivl_cnt_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [3:0]          debt_d;
    logic                tick;
    logic                cmd_acc;
    logic                ref_acc;

    assign tick    = ref_en && (ivl_cnt_q == '0);
    assign cmd_acc = ref_bus.ref_cmd_valid && ref_bus.ref_cmd_ready;
    assign ref_acc = cmd_acc && (state_q == S_REF);

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            ivl_cnt_q <= CNT_W'(TREFI_CYC - 1);
        end else if (ref_en) begin
            ivl_cnt_q <= (ivl_cnt_q == '0) ? CNT_W'(TREFI_CYC - 1) : ivl_cnt_q - CNT_W'(1);
        end
    end

    // Tick and REF accept in the same cycle cancel; a tick at the ceiling is dropped.
    always_comb begin
        debt_d = ref_debt;
        if (tick && !ref_acc) begin
            if (ref_debt != DEBT_MAX) debt_d = ref_debt + 4'd1;
        end else if (ref_acc && !tick) begin
            debt_d = ref_debt - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (ref_en && (ref_debt != '0) && (ref_bus.tran_idle || (ref_debt >= DEBT_URG)))
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (ref_bus.hold_ack) state_d = S_PREA;
            end
            S_PREA: begin
                if (cmd_acc) begin
                    state_d = S_TRP;
                    wait_d  = WAIT_W'(TRP_CYC - 1);
                end
            end
            S_TRP: begin
                if (wait_q == '0) state_d = S_REF;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_REF: begin
                if (cmd_acc) begin
                    state_d = S_TRFC;
                    wait_d  = WAIT_W'(TRFC_CYC - 1);
                end
            end
            S_TRFC: begin
                // Remaining debt is flushed under the same hold, rows are already closed.
                if (wait_q == '0) state_d = (ref_debt != '0) ? S_REF : S_IDLE;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_q               <= S_IDLE;
            wait_q                <= '0;
            ref_debt              <= '0;
            ref_urgent            <= 1'b0;
            ref_done              <= 1'b0;
            ref_bus.hold_req      <= 1'b0;
            ref_bus.ref_cmd_valid <= 1'b0;
            ref_bus.ref_cmd_type  <= 2'b00;
        end else begin
            state_q               <= state_d;
            wait_q                <= wait_d;
            ref_debt              <= debt_d;
            ref_urgent            <= (debt_d >= DEBT_URG);
            ref_done              <= (state_q == S_TRFC) && (state_d == S_IDLE);
            ref_bus.hold_req      <= (state_d != S_IDLE);
            ref_bus.ref_cmd_valid <= (state_d == S_PREA) || (state_d == S_REF);
            ref_bus.ref_cmd_type  <= (state_d == S_PREA) ? 2'b01 :
                                     (state_d == S_REF)  ? 2'b10 : 2'b00;
        end
    end

`ifdef REFSCHED_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            ovf_q <= 1'b0;
        end else if (tick && !ref_acc && (ref_debt == DEBT_MAX)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ref_overflow = ovf_q;
`else
    assign ref_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_refresh_sched.sv
// Randomised and directed bench for refresh_sched against a timestamp-based reference model.
module tb_refresh_sched;

    localparam int unsigned TREFI = 100;
    localparam int unsigned TRP   = 4;
    localparam int unsigned TRFC  = 65;
    localparam int unsigned MAXD  = 8;
    localparam int unsigned URG   = 6;

`ifdef REFSCHED_OVERFLOW_EN
    localparam bit OVF_BUILT = 1'b1;
`else
    localparam bit OVF_BUILT = 1'b0;
`endif

    logic       core_clk = 1'b0;
    logic       core_arstn;
    logic       ref_en;
    logic [3:0] ref_debt;
    logic       ref_urgent;
    logic       ref_done;
    logic       ref_overflow;

    refresh_sched_if bus_if ();

    refresh_sched #(
        .TREFI_CYC  (TREFI),
        .TRP_CYC    (TRP),
        .TRFC_CYC   (TRFC),
        .MAX_DEBT   (MAXD),
        .URGENT_DEBT(URG)
    ) dut (
        .core_clk    (core_clk),
        .core_arstn  (core_arstn),
        .ref_en      (ref_en),
        .ref_bus     (bus_if),
        .ref_debt    (ref_debt),
        .ref_urgent  (ref_urgent),
        .ref_done    (ref_done),
        .ref_overflow(ref_overflow)
    );

    always #5 core_clk = ~core_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. m_phase: 0 no hold, 1 hold awaiting ack, 2 command offered, 3 timed gap.
    int m_cyc, m_en_cnt, m_debt, m_phase, m_cmd, m_until;
    bit m_gap_after_ref, m_done, m_ovf;

    task automatic model_reset();
        m_cyc = 0; m_en_cnt = 0; m_debt = 0; m_phase = 0; m_cmd = 0; m_until = 0;
        m_gap_after_ref = 0; m_done = 0; m_ovf = 0;
    endtask

    function automatic bit tick_next();
        return ref_en && (((m_en_cnt + 1) % TREFI) == 0);
    endfunction

    task automatic model_step();
        bit tick, acc, ref_acc;
        m_cyc++;
        tick    = tick_next();
        m_en_cnt += ref_en ? 1 : 0;
        acc     = (m_phase == 2) && bus_if.ref_cmd_ready;
        ref_acc = acc && (m_cmd == 2);
        m_done  = 0;
        case (m_phase)
            0: if (ref_en && m_debt > 0 && (bus_if.tran_idle || m_debt >= URG)) m_phase = 1;
            1: if (bus_if.hold_ack) begin m_phase = 2; m_cmd = 1; end
            2: if (acc) begin
                   m_phase = 3;
                   m_gap_after_ref = (m_cmd == 2);
                   m_until = m_cyc + ((m_cmd == 2) ? TRFC : TRP);
                   m_cmd = 0;
               end
            default: if (m_cyc == m_until) begin
                   if (!m_gap_after_ref || m_debt > 0) begin m_phase = 2; m_cmd = 2; end
                   else begin m_phase = 0; m_done = 1; end
               end
        endcase
        if (tick && !ref_acc) begin
            if (m_debt == MAXD) m_ovf = m_ovf | OVF_BUILT;
            else m_debt++;
        end else if (ref_acc && !tick) begin
            m_debt--;
        end
    endtask

    function automatic logic [10:0] dut_outs();
        return {bus_if.hold_req, bus_if.ref_cmd_valid, bus_if.ref_cmd_type,
                ref_debt, ref_urgent, ref_done, ref_overflow};
    endfunction

    function automatic logic [10:0] exp_outs();
        logic [1:0] t;
        t = (m_phase == 2) ? 2'(m_cmd) : 2'b00;
        return {m_phase != 0, m_phase == 2, t, 4'(m_debt), m_debt >= URG, m_done, m_ovf};
    endfunction

    task automatic step();
        @(posedge core_clk);
        model_step();
        @(negedge core_clk);
        chk("outs", 32'(dut_outs()), 32'(exp_outs()));
    endtask

    task automatic drive_ack(input int pct);
        if (m_phase == 0) bus_if.hold_ack = 1'b0;
        else if (!bus_if.hold_ack) bus_if.hold_ack = (int'($urandom_range(99)) < pct);
    endtask

    task automatic apply_reset();
        @(negedge core_clk);
        #2;
        core_arstn = 1'b0;
        model_reset();
        #1;
        chk("rst_outs", 32'(dut_outs()), 32'd0);
        ref_en = 1'b0; bus_if.tran_idle = 1'b0; bus_if.hold_ack = 1'b0; bus_if.ref_cmd_ready = 1'b0;
        @(negedge core_clk);
        @(negedge core_clk);
        core_arstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hold, done_at, prea_n, ref_n, t, bp_k;
        bit busy_done, hold_seen, aligned;

        core_arstn = 1'b0; ref_en = 1'b0;
        bus_if.tran_idle = 1'b0; bus_if.hold_ack = 1'b0; bus_if.ref_cmd_ready = 1'b0;
        model_reset();

        // Idle bus: one tick, one full PREA/REF sequence.
        apply_reset();
        ref_en = 1'b1; bus_if.tran_idle = 1'b1; bus_if.ref_cmd_ready = 1'b1;
        first_hold = -1; done_at = -1;
        for (int i = 0; i < 400 && done_at < 0; i++) begin
            drive_ack(100);
            step();
            if (bus_if.hold_req && first_hold < 0) first_hold = m_cyc;
            if (ref_done) done_at = m_cyc;
        end
        chk("idle_hold_rise", first_hold, TREFI + 1);
        chk("idle_done", done_at, TREFI + 3 + TRP + 1 + TRFC);
        chk("idle_debt", ref_debt, 0);

        // Busy postponement to the urgent threshold, ref_en dropped mid-sequence.
        bus_if.tran_idle = 1'b0;
        prea_n = 0; ref_n = 0; busy_done = 0; hold_seen = 0;
        for (int i = 0; i < 2000 && !busy_done; i++) begin
            drive_ack(100);
            step();
            if (bus_if.hold_req && !hold_seen) begin
                hold_seen = 1;
                ref_en = 1'b0;
                chk("busy_debt_at_hold", ref_debt, URG);
            end
            if (bus_if.ref_cmd_valid && bus_if.ref_cmd_type == 2'b01) prea_n++;
            if (bus_if.ref_cmd_valid && bus_if.ref_cmd_type == 2'b10) ref_n++;
            if (ref_done) busy_done = 1;
        end
        chk("busy_done", busy_done, 1);
        chk("busy_prea_count", prea_n, 1);
        chk("busy_ref_count", ref_n, URG);
        chk("busy_debt_end", ref_debt, 0);
        ref_en = 1'b1;

        // Tick coinciding with the REF accept at debt 3.
        apply_reset();
        ref_en = 1'b1; bus_if.tran_idle = 1'b0; bus_if.ref_cmd_ready = 1'b0;
        for (int i = 0; i < 400 && m_debt < 3; i++) begin drive_ack(100); step(); end
        bus_if.tran_idle = 1'b1;
        aligned = 0;
        for (int i = 0; i < 300 && !aligned; i++) begin
            drive_ack(100);
            aligned = (m_phase == 2) && (m_cmd == 2) && tick_next();
            bus_if.ref_cmd_ready = (m_phase == 2) && ((m_cmd == 1) || aligned);
            step();
        end
        chk("tick_acc_aligned", aligned, 1);
        chk("tick_acc_debt", ref_debt, 3);
        bus_if.ref_cmd_ready = 1'b1;
        for (int i = 0; i < 1000 && m_phase != 0; i++) begin drive_ack(100); step(); end

        // Overflow: no hold_ack, nine ticks.
        apply_reset();
        ref_en = 1'b1; bus_if.tran_idle = 1'b1; bus_if.ref_cmd_ready = 1'b1;
        for (int i = 0; i < 9 * TREFI + 2; i++) begin drive_ack(0); step(); end
        chk("ovf_debt", ref_debt, MAXD);
        chk("ovf_flag", ref_overflow, OVF_BUILT);
        chk("ovf_hold_pending", bus_if.hold_req, 1);

        // Backpressure on PREA for 10 cycles.
        bus_if.ref_cmd_ready = 1'b0;
        for (int i = 0; i < 10 && m_phase != 2; i++) begin drive_ack(100); step(); end
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_prea_stable", {bus_if.ref_cmd_valid, bus_if.ref_cmd_type}, 3'b101);
        end
        bus_if.ref_cmd_ready = 1'b1;
        step();
        bp_k = 0;
        for (int i = 0; i < 20 && !bus_if.ref_cmd_valid; i++) begin step(); bp_k++; end
        chk("bp_trp_gap", bp_k, TRP);

        // Asynchronous reset in the middle of tRFC.
        for (int i = 0; i < 800 && !(m_phase == 3 && m_gap_after_ref); i++) begin drive_ack(100); step(); end
        for (int i = 0; i < 5; i++) step();
        apply_reset();
        ref_en = 1'b1; bus_if.tran_idle = 1'b0; bus_if.ref_cmd_ready = 1'b1;
        t = -1;
        for (int i = 0; i < 300 && t < 0; i++) begin
            drive_ack(100);
            step();
            if (ref_debt != 4'd0) t = m_cyc;
        end
        chk("rst_first_tick", t, TREFI);

        // Randomised traffic, enable, ack latency and ready.
        for (int i = 0; i < 5000; i++) begin
            ref_en               = ($urandom_range(15) != 0);
            bus_if.tran_idle     = ($urandom_range(2) == 0);
            bus_if.ref_cmd_ready = ($urandom_range(3) != 0);
            drive_ack(30);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
